// File: rtl/dmem_interface_rv32i.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dmem_interface_rv32i
// Memory-stage data port of the RV32I pipeline. Converts the M-stage
// load/store into a single req/ack transaction on the shared data bus and
// returns aligned, sign-/zero-extended load data to writeback.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   mem_read_M        : M-stage instruction is a load
//   mem_write_M       : M-stage instruction is a store (wins over load)
//   funct3_M          : RV32I width/sign code (011/110/111 act as word)
//   addr_M            : byte address
//   write_data_M      : store data (rs2)
//   enable_memory     : M-stage advance enable, releases DONE
//   mem_transaction   : combinational, mem_read_M | mem_write_M
//   data_ready        : transaction complete (registered)
//   read_data_M       : extended load data, valid while data_ready=1
//   misaligned        : access was unaligned, no bus request issued
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be : registered bus request
//   bus_ack, bus_rdata: one-cycle completion pulse and read word
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   Adds a BUSY watchdog of TIMEOUT_CYCLES cycles and the bus_error output.
// ---------------------------------------------------------------------------
module dmem_interface_rv32i #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read_M,
   input  logic              mem_write_M,
   input  logic [2:0]        funct3_M,
   input  logic [ADDR_W-1:0] addr_M,
   input  logic [31:0]       write_data_M,
   input  logic              enable_memory,
   output logic              mem_transaction,
   output logic              data_ready,
   output logic [31:0]       read_data_M,
   output logic              misaligned,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
`ifdef DMEM_TIMEOUT_EN
   ,
   output logic              bus_error
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Access size code: 0 = byte, 1 = halfword, 2 = word (undefined codes -> word)
   function automatic logic [1:0] size_code(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: size_code = 2'd0;
         3'b001, 3'b101: size_code = 2'd1;
         default:        size_code = 2'd2;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'd0:    is_misaligned = 1'b0;
         2'd1:    is_misaligned = off[0];
         default: is_misaligned = |off;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'd0:    byte_enables = 4'b0001 << off;
         2'd1:    byte_enables = off[1] ? 4'b1100 : 4'b0011;
         default: byte_enables = 4'b1111;
      endcase
   endfunction

   // Store data replicated across lanes so the enabled lanes see the right bytes
   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'd0:    lane_data = {4{wd[7:0]}};
         2'd1:    lane_data = {2{wd[15:0]}};
         default: lane_data = wd;
      endcase
   endfunction

   // Shift the addressed byte/halfword down to bit 0, then extend; funct3[2] selects unsigned
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size_code(f3))
         2'd0:    load_extend = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
         2'd1:    load_extend = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
         default: load_extend = word;
      endcase
   endfunction

   state_t              state_r, state_s;
   logic                req_r, req_s;
   logic                we_r, we_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [31:0]         wdata_r, wdata_s;
   logic [3:0]          be_r, be_s;
   logic                ready_r, ready_s;
   logic                mis_r, mis_s;
   logic [31:0]         rdata_r, rdata_s;
   logic [2:0]          f3_r, f3_s;
   logic [1:0]          off_r, off_s;
   logic [1:0]          size_s;
   logic                op_s;
`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                err_r, err_s;
`endif

   assign op_s            = mem_read_M | mem_write_M;
   assign size_s          = size_code(funct3_M);
   assign mem_transaction = op_s;
   assign data_ready      = ready_r;
   assign read_data_M     = rdata_r;
   assign misaligned      = mis_r;
   assign bus_req         = req_r;
   assign bus_we          = we_r;
   assign bus_addr        = addr_r;
   assign bus_wdata       = wdata_r;
   assign bus_be          = be_r;
`ifdef DMEM_TIMEOUT_EN
   assign bus_error       = err_r;
`endif

   // Next-state and next-output logic of the transaction FSM
   always_comb begin
      state_s = state_r;
      req_s   = req_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      be_s    = be_r;
      ready_s = ready_r;
      mis_s   = mis_r;
      rdata_s = rdata_r;
      f3_s    = f3_r;
      off_s   = off_r;
`ifdef DMEM_TIMEOUT_EN
      cnt_s   = cnt_r;
      err_s   = err_r;
`endif
      case (state_r)
         IDLE: begin
            if (op_s) begin
               if (is_misaligned(size_s, addr_M[1:0])) begin
                  state_s = DONE;
                  mis_s   = 1'b1;
                  ready_s = 1'b1;
                  rdata_s = 32'd0;
               end else begin
                  state_s = BUSY;
                  req_s   = 1'b1;
                  we_s    = mem_write_M;
                  addr_s  = {addr_M[ADDR_W-1:2], 2'b00};
                  be_s    = byte_enables(size_s, addr_M[1:0]);
                  wdata_s = lane_data(size_s, write_data_M);
                  f3_s    = funct3_M;
                  off_s   = addr_M[1:0];
`ifdef DMEM_TIMEOUT_EN
                  cnt_s   = '0;
`endif
               end
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (bus_ack) begin
               state_s = DONE;
               req_s   = 1'b0;
               ready_s = 1'b1;
               if (!we_r) begin
                  rdata_s = load_extend(f3_r, off_r, bus_rdata);
               end else begin
                  rdata_s = rdata_r;
               end
`ifdef DMEM_TIMEOUT_EN
            end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_s = DONE;
               req_s   = 1'b0;
               ready_s = 1'b1;
               rdata_s = 32'd0;
               err_s   = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
`else
            end else begin
               state_s = BUSY;
            end
`endif
         end
         DONE: begin
            if (enable_memory) begin
               state_s = IDLE;
               ready_s = 1'b0;
               mis_s   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
               err_s   = 1'b0;
`endif
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = 1'b0;
            ready_s = 1'b0;
            mis_s   = 1'b0;
         end
      endcase
   end

   // State and registered bus/result outputs; reset drops bus_req at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         be_r    <= 4'd0;
         ready_r <= 1'b0;
         mis_r   <= 1'b0;
         rdata_r <= 32'd0;
         f3_r    <= 3'd0;
         off_r   <= 2'd0;
`ifdef DMEM_TIMEOUT_EN
         cnt_r   <= '0;
         err_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         req_r   <= req_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         be_r    <= be_s;
         ready_r <= ready_s;
         mis_r   <= mis_s;
         rdata_r <= rdata_s;
         f3_r    <= f3_s;
         off_r   <= off_s;
`ifdef DMEM_TIMEOUT_EN
         cnt_r   <= cnt_s;
         err_r   <= err_s;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_interface_rv32i.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_interface_rv32i: directed vector table,
// randomized transactions against a behavioural model, and hand-written
// reset / stray-ack / watchdog sequences.
module tb_dmem_interface_rv32i;

   localparam int TB_TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_M, mem_write_M, enable_memory, bus_ack;
   logic [2:0]  funct3_M;
   logic [31:0] addr_M, write_data_M, bus_rdata;
   logic        mem_transaction, data_ready, misaligned, bus_req, bus_we;
   logic [31:0] read_data_M, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
`ifdef DMEM_TIMEOUT_EN
   logic        bus_error;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int req_count = 0;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   dmem_interface_rv32i #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
      .clk(clk), .rst(rst),
      .mem_read_M(mem_read_M), .mem_write_M(mem_write_M), .funct3_M(funct3_M),
      .addr_M(addr_M), .write_data_M(write_data_M), .enable_memory(enable_memory),
      .mem_transaction(mem_transaction), .data_ready(data_ready),
      .read_data_M(read_data_M), .misaligned(misaligned),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef DMEM_TIMEOUT_EN
      , .bus_error(bus_error)
`endif
   );

   // Count bus request rising edges, sampled mid-cycle
   always @(negedge clk) begin
      if (bus_req && !req_prev) req_count <= req_count + 1;
      req_prev <= bus_req;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rword;
      int          delay;
      int          hold;
      logic        e_mis;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: derive expectations from byte-level arithmetic on size and offset
   function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rword, input int delay, input int hold);
      vec_t v;
      int size, off;
      logic [31:0] val;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
      off  = int'(addr % 32'd4);
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rword = rword;
      v.delay = delay; v.hold = hold;
      v.e_mis = (off % size) != 0;
      v.e_be  = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) v.e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      val = rword >> (8 * off);
      if (size == 1) begin
         val = val & 32'h0000_00FF;
         if (f3 < 3'd4 && val[7]) val = val | 32'hFFFF_FF00;
      end else if (size == 2) begin
         val = val & 32'h0000_FFFF;
         if (f3 < 3'd4 && val[15]) val = val | 32'hFFFF_0000;
      end
      v.e_rdata = v.e_mis ? 32'd0 : val;
      return v;
   endfunction

   // Run one M-stage operation end to end and check every cycle of it
   task automatic do_txn(input vec_t v, input string tag);
      int reqs_before;
      logic [31:0] e_addr;
      e_addr      = {v.addr[31:2], 2'b00};
      reqs_before = req_count;
      mem_read_M = v.rd; mem_write_M = v.wr; funct3_M = v.f3;
      addr_M = v.addr; write_data_M = v.wd; enable_memory = 1'b0; bus_ack = 1'b0;
      #1;
      chk({tag, ".mem_transaction"}, mem_transaction, 32'd1);
      tick();
      if (v.e_mis) begin
         chk({tag, ".misaligned"}, misaligned, 32'd1);
         chk({tag, ".ready_mis"}, data_ready, 32'd1);
         chk({tag, ".no_req"}, bus_req, 32'd0);
         chk({tag, ".rdata_mis"}, read_data_M, 32'd0);
      end else begin
         for (int k = 0; k <= v.delay; k++) begin
            chk({tag, ".bus_req"}, bus_req, 32'd1);
            chk({tag, ".bus_we"}, bus_we, 32'(v.wr));
            chk({tag, ".bus_addr"}, bus_addr, e_addr);
            chk({tag, ".bus_be"}, bus_be, 32'(v.e_be));
            chk({tag, ".bus_wdata"}, bus_wdata, v.e_wdata);
            chk({tag, ".busy_ready"}, data_ready, 32'd0);
            if (k == v.delay) begin
               bus_ack = 1'b1;
               bus_rdata = v.rword;
            end else begin
               bus_rdata = $urandom;
            end
            tick();
         end
         bus_ack = 1'b0;
         bus_rdata = $urandom;
         chk({tag, ".data_ready"}, data_ready, 32'd1);
         chk({tag, ".req_drop"}, bus_req, 32'd0);
         chk({tag, ".not_mis"}, misaligned, 32'd0);
         if (!v.wr) chk({tag, ".read_data"}, read_data_M, v.e_rdata);
      end
      for (int h = 0; h < v.hold; h++) begin
         tick();
         chk({tag, ".hold_ready"}, data_ready, 32'd1);
         chk({tag, ".hold_req"}, bus_req, 32'd0);
         if (!v.wr || v.e_mis) chk({tag, ".hold_rdata"}, read_data_M, v.e_rdata);
      end
      enable_memory = 1'b1;
      mem_read_M = 1'b0; mem_write_M = 1'b0;
      tick();
      enable_memory = 1'b0;
      chk({tag, ".ready_clr"}, data_ready, 32'd0);
      chk({tag, ".mis_clr"}, misaligned, 32'd0);
      chk({tag, ".idle_req"}, bus_req, 32'd0);
      chk({tag, ".req_count"}, 32'(req_count - reqs_before), v.e_mis ? 32'd0 : 32'd1);
   endtask

   vec_t vecs[15];

   initial begin
      vec_t rv;
      int   r;
      rst = 1'b0; mem_read_M = 1'b0; mem_write_M = 1'b0; funct3_M = 3'd0;
      addr_M = 32'd0; write_data_M = 32'd0; enable_memory = 1'b0;
      bus_ack = 1'b0; bus_rdata = 32'd0;

      //          rd    wr    f3      addr          wd            rword         dly hld mis   be       wdata         rdata
      vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1'b0, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_0000, 32'h8011_2233, 0, 0, 1'b0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0000_0000, 32'h8011_2233, 0, 0, 1'b0, 4'b1000, 32'h0000_0000, 32'h0000_0080};
      vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0000_0000, 32'h8011_2233, 0, 0, 1'b0, 4'b1100, 32'h0000_0000, 32'h0000_8011};
      vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0000, 0, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000};
      vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0000_0000, 32'h1111_1111, 0, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
      vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0000_0000, 4, 2, 1'b0, 4'b1111, 32'h1234_5678, 32'h0000_0000};
      vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_0000, 32'h8011_2233, 0, 1, 1'b0, 4'b1100, 32'h0000_0000, 32'hFFFF_8011};
      vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0000_0000, 32'h1234_7FFF, 1, 0, 1'b0, 4'b0011, 32'h0000_0000, 32'h0000_7FFF};
      vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0000_0000, 0, 0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0000_0000};
      vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0000_0000, 32'h2222_2222, 0, 1, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
      vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0000_0000, 32'hCAFE_F00D, 0, 1, 1'b0, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D};
      vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h0000_0106, 32'h0000_0000, 32'h3333_3333, 0, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
      vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h55AA_55AA, 32'h0000_0000, 2, 0, 1'b0, 4'b1111, 32'h55AA_55AA, 32'h0000_0000};
      vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0000_0000, 32'h007F_0000, 0, 0, 1'b0, 4'b0100, 32'h0000_0000, 32'h0000_007F};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.bus_req", bus_req, 32'd0);
      chk("rst.bus_we", bus_we, 32'd0);
      chk("rst.data_ready", data_ready, 32'd0);
      chk("rst.misaligned", misaligned, 32'd0);
      chk("rst.bus_addr", bus_addr, 32'd0);
      chk("rst.bus_wdata", bus_wdata, 32'd0);
      chk("rst.bus_be", 32'(bus_be), 32'd0);
      chk("rst.read_data", read_data_M, 32'd0);
      #3 rst = 1'b1;
      tick();

      for (int i = 0; i < 15; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // Stray acks in IDLE are ignored
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      tick(); tick();
      bus_ack = 1'b0;
      chk("stray_ack.ready", data_ready, 32'd0);
      chk("stray_ack.req", bus_req, 32'd0);

      // Reset while BUSY drops bus_req without waiting for a clock edge
      mem_read_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h0000_0500;
      tick();
      chk("rstbusy.req_before", bus_req, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstbusy.req_async", bus_req, 32'd0);
      mem_read_M = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      chk("rstbusy.ack_ignored", data_ready, 32'd0);
      chk("rstbusy.rdata", read_data_M, 32'd0);
      bus_ack = 1'b0;
      #3 rst = 1'b1;
      tick();
      chk("rstbusy.idle_req", bus_req, 32'd0);
      chk("rstbusy.idle_ready", data_ready, 32'd0);
      do_txn(vecs[0], "after_rst");

`ifdef DMEM_TIMEOUT_EN
      // Watchdog: no ack ever arrives
      mem_read_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h0000_0400;
      tick();
      mem_read_M = 1'b0;
      for (int k = 0; k < TB_TO; k++) begin
         chk("timeout.req_held", bus_req, 32'd1);
         chk("timeout.err_low", bus_error, 32'd0);
         tick();
      end
      chk("timeout.bus_error", bus_error, 32'd1);
      chk("timeout.ready", data_ready, 32'd1);
      chk("timeout.req_drop", bus_req, 32'd0);
      chk("timeout.rdata", read_data_M, 32'd0);
      enable_memory = 1'b1;
      tick();
      enable_memory = 1'b0;
      chk("timeout.err_clr", bus_error, 32'd0);
`endif

      // Randomized transactions against the model
      for (int n = 0; n < 40; n++) begin
         r  = int'($urandom_range(1, 3));
         rv = model(r[0], r[1], 3'($urandom_range(0, 7)),
                    32'h0000_1000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         do_txn(rv, $sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
